// File: rtl/rcc_ker_clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rcc_ker_clk_sel_ctrl
// Brief    : Gate-off / switch / settle sequencer for an N-input glitch-free
//            kernel clock switch, with ready timeout and safe-source fallback.
// Revision : 1.0
// ============================================================================
module rcc_ker_clk_sel_ctrl #(
    parameter int SRC_NUM     = 4,
    parameter int SEL_W       = 2,
    parameter int SAFE_SRC    = 1,
    parameter int GATE_DLY    = 4,
    parameter int RDY_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic [SRC_NUM-1:0] src_rdy_i,
    input  logic [SRC_NUM-1:0] src_fail_i,
    input  logic               fb_clr_i,
    output logic [SRC_NUM-1:0] mux_sel_oh_o,
    output logic               gate_en_o,
    output logic [SEL_W-1:0]   cur_sel_o,
    output logic               busy_o,
    output logic               fallback_o,
    output logic               fail_irq_o,
    output logic               switch_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_RUN      = 3'd3,
        ST_GATE_OFF = 3'd4
    } state_e;

    localparam logic [SEL_W-1:0] c_safe_sel = SEL_W'(SAFE_SRC);
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_dly_last = CNT_W'(GATE_DLY - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_e             state_q;
    logic [CNT_W-1:0]   timer_q;
    logic [SEL_W-1:0]   tgt_q;
    logic [SRC_NUM-1:0] mux_sel_oh_q;
    logic               gate_en_q;
    logic [SEL_W-1:0]   cur_sel_q;
    logic               busy_q;
    logic               fallback_q;
    logic               fail_irq_q;
    logic               switch_err_q;

    logic               w_sel_valid;
    logic [SEL_W-1:0]   w_req;
    logic               w_req_valid;
    logic               w_tgt_fail;
    logic               w_tgt_rdy;
    logic               w_cur_fail;
    logic               w_cur_is_safe;

    function automatic logic [SRC_NUM-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        logic [SRC_NUM-1:0] oh;
        oh = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (idx == SEL_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // While fallback is sticky the register select is ignored entirely.
    assign w_sel_valid   = ({1'b0, sel_i} < (SEL_W + 1)'(SRC_NUM));
    assign w_req         = fallback_q ? c_safe_sel : sel_i;
    assign w_req_valid   = fallback_q | w_sel_valid;
    assign w_tgt_fail    = |(f_onehot(tgt_q) & src_fail_i);
    assign w_tgt_rdy     = |(f_onehot(tgt_q) & src_rdy_i);
    assign w_cur_fail    = |(f_onehot(cur_sel_q) & src_fail_i);
    assign w_cur_is_safe = (cur_sel_q == c_safe_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            tgt_q        <= '0;
            mux_sel_oh_q <= '0;
            gate_en_q    <= 1'b0;
            cur_sel_q    <= '0;
            busy_q       <= 1'b0;
            fallback_q   <= 1'b0;
            fail_irq_q   <= 1'b0;
            switch_err_q <= 1'b0;
        end else begin
            fail_irq_q   <= 1'b0;
            switch_err_q <= 1'b0;
            // A fallback set later in this block overrides the clear.
            if (fb_clr_i) begin
                fallback_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (en_i && w_req_valid) begin
                        tgt_q   <= w_req;
                        timer_q <= '0;
                        state_q <= ST_WAIT_RDY;
                        busy_q  <= 1'b1;
                    end
                end

                ST_WAIT_RDY: begin
                    if (w_tgt_fail || (timer_q == c_tmo_last)) begin
                        switch_err_q <= 1'b1;
                        if (tgt_q == c_safe_sel) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            tgt_q      <= c_safe_sel;
                            fallback_q <= 1'b1;
                            timer_q    <= '0;
                        end
                    end else if (w_tgt_rdy) begin
                        mux_sel_oh_q <= f_onehot(tgt_q);
                        cur_sel_q    <= tgt_q;
                        timer_q      <= '0;
                        state_q      <= ST_SETTLE;
                    end else begin
                        timer_q <= timer_q + c_cnt_one;
                    end
                end

                ST_SETTLE: begin
                    if (w_cur_fail && !w_cur_is_safe) begin
                        gate_en_q  <= 1'b0;
                        fail_irq_q <= 1'b1;
                        fallback_q <= 1'b1;
                        tgt_q      <= c_safe_sel;
                        timer_q    <= '0;
                        state_q    <= ST_GATE_OFF;
                    end else if (timer_q == c_dly_last) begin
                        gate_en_q <= en_i;
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + c_cnt_one;
                    end
                end

                ST_RUN: begin
                    gate_en_q <= en_i;
                    if (w_cur_fail && !w_cur_is_safe) begin
                        gate_en_q  <= 1'b0;
                        fail_irq_q <= 1'b1;
                        fallback_q <= 1'b1;
                        tgt_q      <= c_safe_sel;
                        timer_q    <= '0;
                        state_q    <= ST_GATE_OFF;
                        busy_q     <= 1'b1;
                    end else if (w_cur_fail) begin
                        // Nothing left to fall back to: shut the output down.
                        gate_en_q    <= 1'b0;
                        mux_sel_oh_q <= '0;
                        switch_err_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (w_req_valid && (w_req != cur_sel_q)) begin
                        gate_en_q <= 1'b0;
                        tgt_q     <= w_req;
                        timer_q   <= '0;
                        state_q   <= ST_GATE_OFF;
                        busy_q    <= 1'b1;
                    end
                end

                ST_GATE_OFF: begin
                    if (timer_q == c_dly_last) begin
                        mux_sel_oh_q <= '0;
                        timer_q      <= '0;
                        state_q      <= ST_WAIT_RDY;
                    end else begin
                        timer_q <= timer_q + c_cnt_one;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mux_sel_oh_o = mux_sel_oh_q;
    assign gate_en_o    = gate_en_q;
    assign cur_sel_o    = cur_sel_q;
    assign busy_o       = busy_q;
    assign fallback_o   = fallback_q;
    assign fail_irq_o   = fail_irq_q;
    assign switch_err_o = switch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rcc_ker_clk_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rcc_ker_clk_sel_ctrl
// Brief    : Table-driven self-checking bench for the kernel clock sequencer.
// Revision : 1.0
// ============================================================================
module tb_rcc_ker_clk_sel_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic [1:0] sel      = 2'd0;
    logic [3:0] src_rdy  = 4'd0;
    logic [3:0] src_fail = 4'd0;
    logic       fb_clr   = 1'b0;

    logic [3:0] mux_sel_oh;
    logic       gate_en;
    logic [1:0] cur_sel;
    logic       busy;
    logic       fallback;
    logic       fail_irq;
    logic       switch_err;

    always #5 clk = ~clk;

    rcc_ker_clk_sel_ctrl #(
        .SRC_NUM     (4),
        .SEL_W       (2),
        .SAFE_SRC    (1),
        .GATE_DLY    (4),
        .RDY_TIMEOUT (255),
        .CNT_W       (8)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .sel_i        (sel),
        .src_rdy_i    (src_rdy),
        .src_fail_i   (src_fail),
        .fb_clr_i     (fb_clr),
        .mux_sel_oh_o (mux_sel_oh),
        .gate_en_o    (gate_en),
        .cur_sel_o    (cur_sel),
        .busy_o       (busy),
        .fallback_o   (fallback),
        .fail_irq_o   (fail_irq),
        .switch_err_o (switch_err)
    );

    typedef struct packed {
        logic [3:0] m;
        logic       g;
        logic [1:0] c;
        logic       b;
        logic       f;
        logic       i;
        logic       s;
    } obs_t;

    typedef struct packed {
        logic       en;
        logic [1:0] sel;
        logic [3:0] rdy;
        logic [3:0] fail;
        logic       clr;
        int         cyc;
        obs_t       exp;
    } vec_t;

    int   checks   = 0;
    int   errors   = 0;
    int   irq_cnt  = 0;
    int   serr_cnt = 0;
    obs_t sb_q[$];
    vec_t tbl[22];

    logic [3:0] prev_mux  = 4'd0;
    logic       prev_gate = 1'b0;

    function automatic obs_t mo(input logic [3:0] m, input logic g, input logic [1:0] c,
                                input logic b, input logic f, input logic i, input logic s);
        obs_t o;
        o.m = m; o.g = g; o.c = c; o.b = b; o.f = f; o.i = i; o.s = s;
        return o;
    endfunction

    function automatic vec_t mv(input logic e, input logic [1:0] sl, input logic [3:0] r,
                                input logic [3:0] fl, input logic cl, input int n, input obs_t x);
        vec_t v;
        v.en = e; v.sel = sl; v.rdy = r; v.fail = fl; v.clr = cl; v.cyc = n; v.exp = x;
        return v;
    endfunction

    function automatic obs_t now_obs();
        return mo(mux_sel_oh, gate_en, cur_sel, busy, fallback, fail_irq, switch_err);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push the expectation, advance, then pop it against what the DUT shows.
    task automatic expect_after(input string name, input int n, input obs_t x);
        obs_t e;
        sb_q.push_back(x);
        step(n);
        e = sb_q.pop_front();
        check(name, 32'(now_obs()), 32'(e));
    endtask

    // Pulse counting and mux-change safety, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fail_irq)   irq_cnt++;
            if (switch_err) serr_cnt++;
            if (mux_sel_oh !== prev_mux) begin
                check("mux_onehot0", 32'($onehot0(mux_sel_oh)), 32'd1);
                if (mux_sel_oh != 4'd0) check("mux_chg_while_gated", 32'(prev_gate), 32'd0);
            end
        end
        prev_mux  = mux_sel_oh;
        prev_gate = gate_en;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        // en sel rdy fail clr cyc | mux gate cur busy fb irq serr
        tbl[0]  = mv(1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0, 1, mo(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[1]  = mv(1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0, 1, mo(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[2]  = mv(1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0, 3, mo(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[3]  = mv(1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0, 1, mo(4'b0100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[4]  = mv(1'b1, 2'd3, 4'b1100, 4'b0000, 1'b0, 1, mo(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[5]  = mv(1'b1, 2'd3, 4'b1100, 4'b0000, 1'b0, 3, mo(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[6]  = mv(1'b1, 2'd3, 4'b1100, 4'b0000, 1'b0, 1, mo(4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[7]  = mv(1'b1, 2'd3, 4'b1100, 4'b0000, 1'b0, 1, mo(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[8]  = mv(1'b1, 2'd3, 4'b1100, 4'b0000, 1'b0, 3, mo(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[9]  = mv(1'b1, 2'd3, 4'b1100, 4'b0000, 1'b0, 1, mo(4'b1000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[10] = mv(1'b0, 2'd3, 4'b1100, 4'b0000, 1'b0, 1, mo(4'b1000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[11] = mv(1'b1, 2'd3, 4'b1100, 4'b0000, 1'b0, 1, mo(4'b1000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[12] = mv(1'b1, 2'd3, 4'b1110, 4'b1000, 1'b0, 1, mo(4'b1000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0));
        tbl[13] = mv(1'b1, 2'd3, 4'b1110, 4'b1000, 1'b0, 4, mo(4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl[14] = mv(1'b1, 2'd3, 4'b1110, 4'b1000, 1'b0, 1, mo(4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl[15] = mv(1'b1, 2'd3, 4'b1110, 4'b1000, 1'b0, 4, mo(4'b0010, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl[16] = mv(1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0, 3, mo(4'b0010, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl[17] = mv(1'b1, 2'd0, 4'b1111, 4'b0000, 1'b1, 1, mo(4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl[18] = mv(1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0, 1, mo(4'b0010, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[19] = mv(1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0, 4, mo(4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[20] = mv(1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0, 1, mo(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl[21] = mv(1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0, 4, mo(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        #12;
        check("reset_values", 32'(now_obs()), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            en       = tbl[i].en;
            sel      = tbl[i].sel;
            src_rdy  = tbl[i].rdy;
            src_fail = tbl[i].fail;
            fb_clr   = tbl[i].clr;
            expect_after($sformatf("vec%0d", i), tbl[i].cyc, tbl[i].exp);
        end
        check("fail_irq_single_pulse", 32'(irq_cnt), 32'd1);
        check("no_switch_err_yet", 32'(serr_cnt), 32'd0);

        // Ready timeout on source 2 while running on source 0.
        sel = 2'd2; src_rdy = 4'b0011;
        expect_after("tmo_gate_off", 1, mo(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("tmo_wait_entry", 4, mo(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            step(1);
            if (switch_err) begin
                k = i;
                break;
            end
        end
        check("tmo_latency", 32'(k), 32'd255);
        check("tmo_fallback", 32'(fallback), 32'd1);
        expect_after("tmo_safe_mux", 1, mo(4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        expect_after("tmo_safe_run", 4, mo(4'b0010, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        check("tmo_serr_single", 32'(serr_cnt), 32'd1);

        // Safe source itself fails while running.
        en = 1'b0; src_fail = 4'b0010;
        expect_after("safe_fail", 1, mo(4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1));
        expect_after("safe_fail_idle", 3, mo(4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        check("safe_fail_serr_cnt", 32'(serr_cnt), 32'd2);
        src_fail = 4'b0000; fb_clr = 1'b1;
        expect_after("fb_clr_idle", 1, mo(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        fb_clr = 1'b0;

        // Asynchronous reset in SETTLE.
        en = 1'b1; sel = 2'd2; src_rdy = 4'b1111;
        expect_after("rst_pre_wait", 1, mo(4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("rst_pre_settle", 2, mo(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(now_obs()), 32'd0);
        step(1);
        check("reset_held", 32'(now_obs()), 32'd0);
        rst_n = 1'b1;
        expect_after("post_rst_wait", 1, mo(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("post_rst_settle", 1, mo(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("post_rst_run", 4, mo(4'b0100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));

        // Select change mid GATE_OFF completes, then re-switches from RUN.
        sel = 2'd3;
        expect_after("chg_gate_off", 1, mo(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        step(2);
        sel = 2'd0;
        expect_after("chg_mux_zero", 2, mo(4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("chg_mux_3", 1, mo(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("chg_run_3", 4, mo(4'b1000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        expect_after("reswitch_off", 1, mo(4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("reswitch_mux_0", 5, mo(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        expect_after("reswitch_run_0", 4, mo(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
